// File: rtl/ej32_ss.sv
// Data-stack responder for the eJ32 core: top element lives in register s,
// the rest spill into a distributed RAM with the deepest entry at mem[0].
module ej32_ss #(
   parameter int DEPTH = 64,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               op,
   input  logic [DW-1:0]            vi,
   output logic [DW-1:0]            s,
   output logic [DW-1:0]            pk,
   output logic [$clog2(DEPTH):0]   cnt,
   output logic                     empty,
   output logic                     full,
   output logic                     ovf,
   output logic                     unf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_PICK = 2'b10;
   localparam logic [1:0] OP_POP  = 2'b11;

   logic [DW-1:0] mem [0:DEPTH-2];

   logic [AW-1:0] pidx;
   logic [AW-1:0] spill_addr;
   logic [AW-1:0] refill_addr;
   logic [AW-1:0] pick_addr;
   logic          pick_ok;
   logic          spill_en;

   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
   assign pidx  = vi[AW-1:0];

   // Addresses wrap modulo DEPTH on purpose: cnt==DEPTH truncates to 0, and
   // the subtractions then land on the correct entry without a wider adder.
   assign spill_addr  = cnt[AW-1:0] - AW'(1);
   assign refill_addr = cnt[AW-1:0] - AW'(2);
   assign pick_addr   = cnt[AW-1:0] - AW'(1) - pidx;
   assign pick_ok     = ({1'b0, pidx} < cnt);
   assign spill_en    = !rst && (op == OP_PUSH) && !empty && !full;

   always_ff @(posedge clk) begin
      if (spill_en)
         mem[spill_addr] <= s;
   end

   // One op per cycle; refused ops raise ovf/unf for the following cycle only.
   always_ff @(posedge clk) begin
      if (rst) begin
         s   <= '0;
         pk  <= '0;
         cnt <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         ovf <= 1'b0;
         unf <= 1'b0;
         case (op)
            OP_PUSH: begin
               if (full) begin
                  ovf <= 1'b1;
               end else begin
                  s   <= vi;
                  cnt <= cnt + CW'(1);
               end
            end
            OP_POP: begin
               if (empty) begin
                  unf <= 1'b1;
               end else begin
                  s   <= (cnt == CW'(1)) ? '0 : mem[refill_addr];
                  cnt <= cnt - CW'(1);
               end
            end
            OP_PICK: begin
               if (!pick_ok) begin
                  pk  <= '0;
                  unf <= 1'b1;
               end else if (pidx == '0) begin
                  pk <= s;
               end else begin
                  pk <= mem[pick_addr];
               end
            end
            OP_NOP: ;
            default: ;
         endcase
      end
   end

endmodule
